// File: rtl/mem_out_reader_if.sv
// mem_out_reader_if: output SRAM bank port plus the valid/ready word stream of the drain controller.
interface mem_out_reader_if #(
  parameter int sram_count = 16,
  parameter int sram_addr  = 4,
  parameter int word_len   = 32
);
  logic [sram_count-1:0]           CEN;
  logic [sram_count-1:0]           WEN;
  logic [sram_count*sram_addr-1:0] A;
  logic [sram_count*word_len-1:0]  D;
  logic [sram_count*word_len-1:0]  Q;
  logic [word_len-1:0]             out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [sram_addr-1:0]            out_row;
  logic [$clog2(sram_count)-1:0]   out_bank;
  logic                            out_last;
  modport master (
    output CEN, WEN, A, D, out_data, out_valid, out_row, out_bank, out_last,
    input  Q, out_ready
  );
  modport slave (
    input  CEN, WEN, A, D, out_data, out_valid, out_row, out_bank, out_last,
    output Q, out_ready
  );
endinterface

// File: rtl/mem_out_reader.sv
// mem_out_reader: drains the output SRAM bank row by row and streams each row's words over valid/ready.
module mem_out_reader #(
  parameter int sram_count = 16,
  parameter int sram_addr  = 4,
  parameter int word_len   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [sram_addr:0]   num_rows,
  mem_out_reader_if.master     bus,
  output logic                 busy,
  output logic                 done
);
  localparam int bw = $clog2(sram_count);
  localparam logic [sram_addr:0] max_rows = (sram_addr+1)'(1) << sram_addr;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, STREAM, DONE} state_t;
  state_t state, next;
  logic [word_len-1:0]  buffer [sram_count];
  logic [sram_addr:0]   count, clamped;
  logic [sram_addr-1:0] row;
  logic [bw-1:0]        bank;
  logic                 xfer, last_bank, more_rows;
  assign clamped   = num_rows > max_rows ? max_rows : num_rows;
  assign xfer      = state == STREAM && bus.out_ready;
  assign last_bank = bank == bw'(sram_count-1);
  assign more_rows = {1'b0, row} + 1'b1 < count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = clamped == '0 ? DONE : READ;
      READ:    next = CAPTURE;
      CAPTURE: next = STREAM;
      STREAM:  if (xfer && last_bank) next = more_rows ? READ : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      row   <= '0;
      bank  <= '0;
      for (int i = 0; i < sram_count; i++) buffer[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        count <= clamped;
        row   <= '0;
      end
      if (state == CAPTURE) begin
        for (int i = 0; i < sram_count; i++) buffer[i] <= bus.Q[word_len*i +: word_len];
        bank <= '0;
      end
      if (xfer) begin
        bank <= bank + 1'b1;
        if (last_bank) row <= row + 1'b1;
      end
    end
  // Stream fields read zero outside STREAM so idle and reset look identical on the bus.
  always_comb begin
    bus.CEN       = state == READ ? '0 : '1;
    bus.WEN       = '1;
    bus.A         = state == READ ? {sram_count{row}} : '0;
    bus.D         = '0;
    bus.out_valid = state == STREAM;
    bus.out_data  = bus.out_valid ? buffer[bank] : '0;
    bus.out_row   = bus.out_valid ? row : '0;
    bus.out_bank  = bus.out_valid ? bank : '0;
    bus.out_last  = bus.out_valid && last_bank && {1'b0, row} + 1'b1 == count;
    busy          = state != IDLE;
    done          = state == DONE;
  end
endmodule

// File: tb/tb_mem_out_reader.sv
// tb_mem_out_reader: directed drains against a preloaded SRAM model with a word-order scoreboard.
module tb_mem_out_reader;
  localparam int N = 16, AW = 4, W = 32;
  logic clk = 0, rst_n = 0, start = 0;
  logic [AW:0] num_rows = '0;
  logic busy, done;
  mem_out_reader_if #(.sram_count(N), .sram_addr(AW), .word_len(W)) bus();
  mem_out_reader #(.sram_count(N), .sram_addr(AW), .word_len(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .bus(bus), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, nwords = 0, cen_low = 0, rd = 0, done_cnt = 0;
  int last_cyc = -1, m_rows = 0, m_row = 0, m_bank = 0, dc = 0, dcnt0 = 0;
  logic stalled = 0;
  logic [W-1:0] s_data;
  logic [AW-1:0] s_row, s_bank;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] word(input int r, input int b);
    return {8'(r), 8'(b), 16'hA5A5};
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++)
      if (!bus.CEN[i]) bus.Q[W*i +: W] <= word(int'(bus.A[AW*i +: AW]), i);
  end
  // Scoreboard: every valid cycle must present the next expected word, advancing only on a transfer.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.CEN !== '1) begin
      cen_low++;
      chk("cen_all_low", 64'(bus.CEN), 64'(0));
      chk("wen_high", 64'(bus.WEN), 64'hFFFF);
      chk("addr_row", bus.A, {N{4'(rd)}});
      rd++;
    end
    if (stalled) begin
      chk("hold_data", 64'(bus.out_data), 64'(s_data));
      chk("hold_row", 64'(bus.out_row), 64'(s_row));
      chk("hold_bank", 64'(bus.out_bank), 64'(s_bank));
    end
    if (bus.out_valid) begin
      chk("data", 64'(bus.out_data), 64'(word(m_row, m_bank)));
      chk("row", 64'(bus.out_row), 64'(m_row));
      chk("bank", 64'(bus.out_bank), 64'(m_bank));
      chk("last", 64'(bus.out_last), 64'(m_bank == N-1 && m_row == m_rows-1));
      stalled = !bus.out_ready;
      s_data = bus.out_data; s_row = bus.out_row; s_bank = bus.out_bank;
      if (bus.out_ready) begin
        nwords++;
        if (m_bank == N-1) begin
          m_bank = 0;
          m_row++;
          if (m_row == m_rows) last_cyc = cyc + 1;
        end else m_bank++;
      end
    end else stalled = 0;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int rows_in, input int exp_rows);
    m_rows = exp_rows; m_row = 0; m_bank = 0; nwords = 0; cen_low = 0; rd = 0; last_cyc = -1;
    tick;
    start = 1;
    num_rows = (AW+1)'(rows_in);
    tick;
    start = 0;
  endtask
  task automatic wait_done(input int lim, output int d);
    d = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (done) begin
        d = cyc;
        break;
      end
    end
    chk("done_seen", 64'(d >= 0), 64'(1));
  endtask
  initial begin
    bus.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_cen", 64'(bus.CEN), 64'hFFFF);
    chk("rst_wen", 64'(bus.WEN), 64'hFFFF);
    chk("rst_a", bus.A, 64'(0));
    chk("rst_d", 64'(bus.D[63:0]), 64'(0));
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_data", 64'(bus.out_data), 64'(0));
    chk("rst_last", 64'(bus.out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    tick;
    rst_n = 1;
    tick;
    // One row: latency and single-row framing.
    run(1, 1);
    @(negedge clk);
    chk("t1_cen_c1", 64'(bus.CEN), 64'(0));
    chk("t1_valid_c1", 64'(bus.out_valid), 64'(0));
    chk("t1_busy", 64'(busy), 64'(1));
    tick;
    @(negedge clk);
    chk("t1_cen_c2", 64'(bus.CEN), 64'hFFFF);
    chk("t1_valid_c2", 64'(bus.out_valid), 64'(0));
    tick;
    @(negedge clk);
    chk("t1_valid_c3", 64'(bus.out_valid), 64'(1));
    chk("t1_first", 64'(bus.out_data), 64'h0000A5A5);
    wait_done(100, dc);
    chk("t1_words", 64'(nwords), 64'(16));
    chk("t1_done_at", 64'(dc), 64'(last_cyc));
    tick;
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'(0));
    chk("t1_idle", 64'(busy), 64'(0));
    // Full bank.
    run(16, 16);
    wait_done(1000, dc);
    chk("t2_words", 64'(nwords), 64'(256));
    chk("t2_cen_cycles", 64'(cen_low), 64'(16));
    chk("t2_done_at", 64'(dc), 64'(last_cyc));
    // Back-pressure with ready pattern 1,0,0,1.
    run(3, 3);
    dc = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
    end
    bus.out_ready = 1;
    chk("t3_done_seen", 64'(dc >= 0), 64'(1));
    chk("t3_words", 64'(nwords), 64'(48));
    // Zero rows, then an over-range count.
    run(0, 0);
    @(negedge clk);
    chk("t4_done_now", 64'(done), 64'(1));
    chk("t4_cen_idle", 64'(bus.CEN), 64'hFFFF);
    tick;
    @(negedge clk);
    chk("t4_done_once", 64'(done), 64'(0));
    chk("t4_no_reads", 64'(cen_low), 64'(0));
    chk("t4_no_words", 64'(nwords), 64'(0));
    run(31, 16);
    wait_done(1000, dc);
    chk("t4_clamp_words", 64'(nwords), 64'(256));
    chk("t4_clamp_reads", 64'(cen_low), 64'(16));
    // Start while busy is ignored.
    run(2, 2);
    repeat (4) tick;
    start = 1;
    num_rows = 5'd5;
    tick;
    start = 0;
    wait_done(500, dc);
    chk("t5_words", 64'(nwords), 64'(32));
    chk("t5_reads", 64'(cen_low), 64'(2));
    // Asynchronous reset during row 2.
    run(4, 4);
    dc = -1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_row == 2) begin
        dc = k;
        break;
      end
    end
    chk("t6_row2_seen", 64'(dc >= 0), 64'(1));
    #2;
    dcnt0 = done_cnt;
    rst_n = 0;
    #1;
    chk("t6_valid", 64'(bus.out_valid), 64'(0));
    chk("t6_cen", 64'(bus.CEN), 64'hFFFF);
    chk("t6_data", 64'(bus.out_data), 64'(0));
    chk("t6_row", 64'(bus.out_row), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    tick;
    rst_n = 1;
    tick;
    chk("t6_no_done", 64'(done_cnt), 64'(dcnt0));
    run(1, 1);
    wait_done(200, dc);
    chk("t6_words", 64'(nwords), 64'(16));
    chk("t6_done_at", 64'(dc), 64'(last_cyc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
